udl_axis_regfile: RTL
=====================

UDL_AXIS_REGFILE -- requirements
Module: udl_axis_regfile

Interface
REQ-001 Parameter ID_WIDTH, default 3: width of the AXI ID fields on all channels.
REQ-002 Parameter REG_NUM, default 16, range 1..1024: number of 32-bit registers.
REQ-003 MAXI_CLK  in  1: single clock; all logic is on the rising edge.
REQ-004 MAXI_RST  in  1: reset, synchronous and active-high.
REQ-005 UDL_AXIS_AW*  in/out  AXI4: AWID, AWADDR[31:0], AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWVALID in; AWREADY out; AWLOCK, AWCACHE, AWPROT, AWREGION and AWQOS are ignored.
REQ-006 UDL_AXIS_W*  in/out  AXI4: WDATA[31:0], WSTRB[3:0], WLAST, WVALID in; WREADY out.
REQ-007 UDL_AXIS_B*  out/in  AXI4: BID, BRESP[1:0], BVALID out; BREADY in.
REQ-008 UDL_AXIS_AR*/R*  AXI4: AR fields as for AW; RID, RDATA[31:0], RRESP[1:0], RLAST, RVALID out; RREADY in.
REQ-009 REG_Q  out  REG_NUM*32: flattened register contents, with register k at bits [32k+31:32k].
REQ-010 WR_PULSE  out  REG_NUM: one-cycle strobe for each register written by an accepted W beat.

Function
REQ-011 Word index SHALL be ADDR[11:2]; an index >= REG_NUM, SIZE != 3'b010, or BURST = 2'b11 marks the beat as an error.
REQ-012 Write FSM SHALL have three states:
- W_IDLE: AWREADY=1; on the AW handshake, latch ID, address, length and burst type, then go to W_DATA.
- W_DATA: WREADY=1; commit one beat per W handshake; leave on the WLAST handshake to W_RESP.
- W_RESP: BVALID=1; on the B handshake return to W_IDLE.
REQ-013 Write commit SHALL update each byte lane i with WSTRB[i]=1, taking effect on the following cycle; an error beat writes nothing and raises no WR_PULSE.
REQ-014 BRESP SHALL be OKAY (2'b00) if no beat errored, else SLVERR (2'b10); BID SHALL equal the latched AWID.
REQ-015 WLAST SHALL be trusted over AWLEN: an early or late WLAST ends the burst on the WLAST beat, and the response is SLVERR.
REQ-016 Read FSM SHALL have two states:
- R_IDLE: ARREADY=1; on the AR handshake go to R_DATA.
- R_DATA: present registered RDATA and RRESP per beat, with RVALID=1 from the cycle after the AR handshake; advance on each R handshake; RLAST=1 on beat ARLEN; after the last handshake return to R_IDLE.
REQ-017 An error read beat SHALL return RDATA=0 and RRESP=SLVERR; RID SHALL equal the latched ARID.
REQ-018 INCR bursts SHALL advance the address by 4 per beat; FIXED bursts SHALL keep the address constant; the 12-bit offset wraps modulo 4 KiB.
REQ-019 Read and write channels SHALL operate concurrently; a read of a register committed in the same cycle returns the old value.
REQ-020 RDATA, RRESP, RLAST and RVALID SHALL stay stable while RVALID=1 and RREADY=0; BVALID and BRESP SHALL likewise stay stable while BREADY=0.

Reset
REQ-021 When MAXI_RST=1, all registers SHALL clear to 0 and both FSMs SHALL go to their IDLE states.
REQ-022 While in reset, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST and WR_PULSE SHALL be 0, and BRESP, RRESP, RDATA, BID and RID SHALL be 0.
REQ-023 A reset asserted mid-burst SHALL abort the burst with no response issued.

Configuration
REQ-024 With UDL_AXIS_WRAP_EN defined, WRAP bursts (2'b10) with LEN in {1,3,7,15} SHALL wrap within a (LEN+1)*4-byte aligned window.
REQ-025 With UDL_AXIS_WRAP_EN undefined, or with any other LEN, every beat of a WRAP burst SHALL be an error beat.

Structure
REQ-026 A shared package udl_axis_pkg SHALL hold the BURST and RESP encodings, the FSM state enums and the default register count.
REQ-027 Burst address generation SHALL be a sub-module, udl_axis_addr_gen, instantiated once per channel.

Verification
REQ-028 Single write: AWADDR=0x08, WDATA=0xDEADBEEF, WSTRB=4'hF -> REG_Q[95:64]=0xDEADBEEF, WR_PULSE[2] pulses, BRESP=00.
REQ-029 Partial strobe: write WSTRB=4'b0101 over 0x11223344, then read -> 0x11AA33CC when WDATA=0xFFAAFFCC.
REQ-030 INCR read: ARADDR=0x00, ARLEN=3 -> four beats returning regs 0..3, RLAST only on beat 4, RID equal to ARID.
REQ-031 Out of range: AWADDR=0x40 with REG_NUM=16 -> no register change and BRESP=10; a read at 0x40 returns 0 with RRESP=10.
REQ-032 Backpressure plus WRAP: RREADY low for 5 cycles mid-burst -> R signals held; with the macro defined, ARADDR=0x0C, WRAP, LEN=3 -> beats 0x0C, 0x00, 0x04, 0x08.

Source files
------------

// File: rtl/udl_axis_pkg.sv
// Shared definitions for the AXI4 register file: burst and response
// encodings, the channel FSM states and the default register count.
package udl_axis_pkg;

  localparam int DEFAULT_REG_NUM = 16;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/udl_axis_addr_gen.sv
// Burst address generator: classifies the current beat as good or error
// and computes the 12-bit offset of the following beat.
// Optional feature macro: UDL_AXIS_WRAP_EN enables WRAP bursts of 2/4/8/16 beats.
module udl_axis_addr_gen
  import udl_axis_pkg::*;
#(
  parameter int REG_NUM = DEFAULT_REG_NUM
) (
  input  logic [11:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [11:0] next_addr,
  output logic        beat_err
);

`ifdef UDL_AXIS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [10:0] reg_limit;
  logic [11:0] incr_addr;
  logic [11:0] wrap_mask;
  logic        wrap_len_ok;
  logic        wrap_ok;

  assign reg_limit   = 11'(REG_NUM);
  assign incr_addr   = addr + 12'd4;
  assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign wrap_ok     = WRAP_EN && wrap_len_ok;
  assign wrap_mask   = {6'd0, len[3:0], 2'b11};

  // Beat classification and next-offset selection per burst type
  always_comb begin
    beat_err = ({1'b0, addr[11:2]} >= reg_limit) || (size != 3'b010) ||
               (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/udl_axis_regfile.sv
// AXI4 slave register file: REG_NUM 32-bit registers with independent
// write (AW/W/B) and read (AR/R) channel FSMs and a write strobe per register.
// Optional feature macro: UDL_AXIS_WRAP_EN (handled in udl_axis_addr_gen).
module udl_axis_regfile
  import udl_axis_pkg::*;
#(
  parameter int ID_WIDTH = 3,
  parameter int REG_NUM  = DEFAULT_REG_NUM
) (
  input  logic                   MAXI_CLK,
  input  logic                   MAXI_RST,
  input  logic [ID_WIDTH-1:0]    UDL_AXIS_AWID,
  input  logic [31:0]            UDL_AXIS_AWADDR,
  input  logic [7:0]             UDL_AXIS_AWLEN,
  input  logic [2:0]             UDL_AXIS_AWSIZE,
  input  logic [1:0]             UDL_AXIS_AWBURST,
  input  logic                   UDL_AXIS_AWLOCK,
  input  logic [3:0]             UDL_AXIS_AWCACHE,
  input  logic [2:0]             UDL_AXIS_AWPROT,
  input  logic [3:0]             UDL_AXIS_AWREGION,
  input  logic [3:0]             UDL_AXIS_AWQOS,
  input  logic                   UDL_AXIS_AWVALID,
  output logic                   UDL_AXIS_AWREADY,
  input  logic [31:0]            UDL_AXIS_WDATA,
  input  logic [3:0]             UDL_AXIS_WSTRB,
  input  logic                   UDL_AXIS_WLAST,
  input  logic                   UDL_AXIS_WVALID,
  output logic                   UDL_AXIS_WREADY,
  output logic [ID_WIDTH-1:0]    UDL_AXIS_BID,
  output logic [1:0]             UDL_AXIS_BRESP,
  output logic                   UDL_AXIS_BVALID,
  input  logic                   UDL_AXIS_BREADY,
  input  logic [ID_WIDTH-1:0]    UDL_AXIS_ARID,
  input  logic [31:0]            UDL_AXIS_ARADDR,
  input  logic [7:0]             UDL_AXIS_ARLEN,
  input  logic [2:0]             UDL_AXIS_ARSIZE,
  input  logic [1:0]             UDL_AXIS_ARBURST,
  input  logic                   UDL_AXIS_ARLOCK,
  input  logic [3:0]             UDL_AXIS_ARCACHE,
  input  logic [2:0]             UDL_AXIS_ARPROT,
  input  logic [3:0]             UDL_AXIS_ARREGION,
  input  logic [3:0]             UDL_AXIS_ARQOS,
  input  logic                   UDL_AXIS_ARVALID,
  output logic                   UDL_AXIS_ARREADY,
  output logic [ID_WIDTH-1:0]    UDL_AXIS_RID,
  output logic [31:0]            UDL_AXIS_RDATA,
  output logic [1:0]             UDL_AXIS_RRESP,
  output logic                   UDL_AXIS_RLAST,
  output logic                   UDL_AXIS_RVALID,
  input  logic                   UDL_AXIS_RREADY,
  output logic [REG_NUM*32-1:0]  REG_Q,
  output logic [REG_NUM-1:0]     WR_PULSE
);

  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [31:0] regs [REG_NUM];

  wr_state_e w_state, w_next;
  logic [ID_WIDTH-1:0] w_id;
  logic [11:0] w_addr, w_next_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst, b_resp;
  logic        w_err, w_err_next, w_beat_err, w_hs;
  logic [REG_NUM-1:0] wr_pulse;

  rd_state_e r_state, r_next;
  logic [ID_WIDTH-1:0] r_id;
  logic [11:0] r_addr, r_ag_addr, r_next_addr;
  logic [7:0]  r_len, r_ag_len, r_cnt;
  logic [2:0]  r_size, r_ag_size;
  logic [1:0]  r_burst, r_ag_burst, r_resp;
  logic [31:0] r_data, r_beat_data;
  logic        r_last, r_beat_err, r_load_first, r_load_next;

  logic unused_inputs;
  assign unused_inputs = ^{UDL_AXIS_AWADDR[31:12], UDL_AXIS_AWLOCK, UDL_AXIS_AWCACHE,
                           UDL_AXIS_AWPROT, UDL_AXIS_AWREGION, UDL_AXIS_AWQOS,
                           UDL_AXIS_ARADDR[31:12], UDL_AXIS_ARLOCK, UDL_AXIS_ARCACHE,
                           UDL_AXIS_ARPROT, UDL_AXIS_ARREGION, UDL_AXIS_ARQOS};

  udl_axis_addr_gen #(.REG_NUM(REG_NUM)) u_wr_addr_gen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(w_next_addr), .beat_err(w_beat_err)
  );

  // The read generator looks at the AR request while idle so beat 0 can be
  // fetched on the AR handshake, and at the latched burst afterwards.
  assign r_ag_addr  = (r_state == R_IDLE) ? UDL_AXIS_ARADDR[11:0] : r_addr;
  assign r_ag_len   = (r_state == R_IDLE) ? UDL_AXIS_ARLEN        : r_len;
  assign r_ag_size  = (r_state == R_IDLE) ? UDL_AXIS_ARSIZE       : r_size;
  assign r_ag_burst = (r_state == R_IDLE) ? UDL_AXIS_ARBURST      : r_burst;

  udl_axis_addr_gen #(.REG_NUM(REG_NUM)) u_rd_addr_gen (
    .addr(r_ag_addr), .len(r_ag_len), .size(r_ag_size), .burst(r_ag_burst),
    .next_addr(r_next_addr), .beat_err(r_beat_err)
  );

  assign w_hs        = (w_state == W_DATA) && UDL_AXIS_WVALID;
  assign w_err_next  = w_err || w_beat_err || (UDL_AXIS_WLAST != (w_cnt == w_len));
  assign r_beat_data = r_beat_err ? 32'd0 : regs[r_ag_addr[IDX_W+1:2]];
  assign r_load_first = (r_state == R_IDLE) && UDL_AXIS_ARVALID;
  assign r_load_next  = (r_state == R_DATA) && UDL_AXIS_RREADY && !r_last;

  // Channel outputs are forced to zero for as long as reset is held
  assign UDL_AXIS_AWREADY = !MAXI_RST && (w_state == W_IDLE);
  assign UDL_AXIS_WREADY  = !MAXI_RST && (w_state == W_DATA);
  assign UDL_AXIS_BVALID  = !MAXI_RST && (w_state == W_RESP);
  assign UDL_AXIS_BRESP   = MAXI_RST ? 2'b00 : b_resp;
  assign UDL_AXIS_BID     = MAXI_RST ? '0 : w_id;
  assign UDL_AXIS_ARREADY = !MAXI_RST && (r_state == R_IDLE);
  assign UDL_AXIS_RVALID  = !MAXI_RST && (r_state == R_DATA);
  assign UDL_AXIS_RLAST   = !MAXI_RST && (r_state == R_DATA) && r_last;
  assign UDL_AXIS_RDATA   = MAXI_RST ? 32'd0 : r_data;
  assign UDL_AXIS_RRESP   = MAXI_RST ? 2'b00 : r_resp;
  assign UDL_AXIS_RID     = MAXI_RST ? '0 : r_id;
  assign WR_PULSE         = MAXI_RST ? '0 : wr_pulse;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
    assign REG_Q[32*g +: 32] = regs[g];
  end

  // Write and read FSM state registers
  always_ff @(posedge MAXI_CLK) begin
    if (MAXI_RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state; WLAST alone ends the data phase
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (UDL_AXIS_AWVALID) w_next = W_DATA;
      W_DATA:  if (UDL_AXIS_WVALID && UDL_AXIS_WLAST) w_next = W_RESP;
      W_RESP:  if (UDL_AXIS_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (UDL_AXIS_ARVALID) r_next = R_DATA;
      R_DATA:  if (UDL_AXIS_RREADY && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write burst tracking: latch AW, step the address, accumulate errors
  always_ff @(posedge MAXI_CLK) begin
    if (MAXI_RST) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0; w_burst <= '0;
      w_cnt <= '0; w_err <= 1'b0; b_resp <= RESP_OKAY;
    end else begin
      if ((w_state == W_IDLE) && UDL_AXIS_AWVALID) begin
        w_id    <= UDL_AXIS_AWID;
        w_addr  <= UDL_AXIS_AWADDR[11:0];
        w_len   <= UDL_AXIS_AWLEN;
        w_size  <= UDL_AXIS_AWSIZE;
        w_burst <= UDL_AXIS_AWBURST;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_next_addr;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err_next;
        if (UDL_AXIS_WLAST) b_resp <= w_err_next ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Register array update with byte strobes, plus the matching write pulse
  always_ff @(posedge MAXI_CLK) begin
    if (MAXI_RST) begin
      for (int k = 0; k < REG_NUM; k++) regs[k] <= '0;
      wr_pulse <= '0;
    end else begin
      for (int k = 0; k < REG_NUM; k++) begin
        wr_pulse[k] <= w_hs && !w_beat_err && (w_addr[11:2] == 10'(k));
        if (w_hs && !w_beat_err && (w_addr[11:2] == 10'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (UDL_AXIS_WSTRB[b]) regs[k][8*b +: 8] <= UDL_AXIS_WDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Read beat pipeline: beat 0 loads on AR, later beats load on each R handshake
  always_ff @(posedge MAXI_CLK) begin
    if (MAXI_RST) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0;
      r_cnt <= '0; r_data <= '0; r_resp <= RESP_OKAY; r_last <= 1'b0;
    end else if (r_load_first) begin
      r_id    <= UDL_AXIS_ARID;
      r_len   <= UDL_AXIS_ARLEN;
      r_size  <= UDL_AXIS_ARSIZE;
      r_burst <= UDL_AXIS_ARBURST;
      r_addr  <= r_next_addr;
      r_cnt   <= '0;
      r_data  <= r_beat_data;
      r_resp  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
      r_last  <= (UDL_AXIS_ARLEN == 8'd0);
    end else if (r_load_next) begin
      r_addr <= r_next_addr;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= r_beat_data;
      r_resp <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
      r_last <= ((r_cnt + 8'd1) == r_len);
    end
  end

endmodule
